fwd_hazard_unit_p: RTL and testbench

- Parametrised operand forwarding and load-use interlock unit for the pipelined SimpleRISC core.
- Sits beside the OF stage. Keeps an internal shadow pipeline holding the destination of every in-flight instruction, so it needs only the OF instruction word, not every stage IR.
- Produces a combinational RW->OF bypass, EX-aligned registered forwarding selects for src1/src2, and a load-use stall with a saturating stall counter.

---
 rtl/fwd_hazard_unit_p_if.sv | 25 ++
 rtl/fwd_hazard_unit_p.sv | 103 ++++++++++
 tb/tb_fwd_hazard_unit_p.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_p_if.sv
// fwd_hazard_unit_p_if: OF-side request and hazard/forwarding response bundle
interface fwd_hazard_unit_p_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  logic [31:0]      of_ir;
  logic             of_valid;
  logic             advance;
  logic             flush;
  logic             stall;
  logic             of_bypass_src1;
  logic             of_bypass_src2;
  logic [SEL_W-1:0] ex_fwd_sel_src1;
  logic [SEL_W-1:0] ex_fwd_sel_src2;
  logic             ex_valid;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output of_ir, of_valid, advance, flush,
    input  stall, of_bypass_src1, of_bypass_src2, ex_fwd_sel_src1, ex_fwd_sel_src2, ex_valid, stall_count
  );
  modport slave (
    input  of_ir, of_valid, advance, flush,
    output stall, of_bypass_src1, of_bypass_src2, ex_fwd_sel_src1, ex_fwd_sel_src2, ex_valid, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit_p.sv
// fwd_hazard_unit_p: shadow-pipeline operand forwarding and load-use interlock beside OF
module fwd_hazard_unit_p #(
  parameter int DEPTH        = 3,
  parameter int SEL_W        = 2,
  parameter int RA_REG       = 15,
  parameter int HAS_ZERO_REG = 0,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_unit_p_if.slave bus
);
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [3:0] RA      = 4'(RA_REG);

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [3:0] dest;
    logic       ld;
  } ent_t;

  ent_t             sh_q [DEPTH];
  ent_t             sh_d [DEPTH];
  ent_t             dec_e;
  logic [SEL_W-1:0] sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op;
  logic             use1, use2, stall, enter, unused_bits;
  logic [3:0]       src1, src2;

  function automatic logic hit(input ent_t e, input logic u, input logic [3:0] s);
    return u & e.v & e.wr & (e.dest == s) & ~((HAS_ZERO_REG != 0) & (e.dest == 4'd0));
  endfunction

  assign op          = bus.of_ir[31:27];
  assign unused_bits = ^bus.of_ir[13:0];

  always_comb begin
    dec_e.v    = 1'b1;
    dec_e.wr   = !(op inside {OP_CMP, OP_NOP, OP_ST, OP_BEQ, OP_BGT, OP_B, OP_RET});
    dec_e.dest = (op == OP_CALL) ? RA : bus.of_ir[25:22];
    dec_e.ld   = (op == OP_LD);
    use1       = (op <= OP_ASR && op != OP_NOT && op != OP_MOV) || op == OP_LD || op == OP_ST || op == OP_RET;
    src1       = (op == OP_RET) ? RA : bus.of_ir[21:18];
    use2       = (op <= OP_ASR && !bus.of_ir[26]) || op == OP_ST;
    src2       = (op == OP_ST) ? bus.of_ir[25:22] : bus.of_ir[17:14];
  end

  // Only a load sitting in EX can be too late to forward into the consumer's EX.
  assign stall = bus.of_valid & ~bus.flush & sh_q[0].ld & (hit(sh_q[0], use1, src1) | hit(sh_q[0], use2, src2));
  assign enter = bus.of_valid & ~stall & ~bus.flush;

  always_comb begin
    sel1_d = '0;
    sel2_d = '0;
    // Scan oldest to youngest so the youngest producer overwrites and wins.
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (hit(sh_q[j], use1, src1)) sel1_d = SEL_W'(j + 1);
      if (hit(sh_q[j], use2, src2)) sel2_d = SEL_W'(j + 1);
    end
    if (!enter) begin
      sel1_d = '0;
      sel2_d = '0;
    end
    sh_d[0] = enter ? dec_e : '0;
    for (int j = 1; j < DEPTH; j++) sh_d[j] = sh_q[j-1];
    cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) sh_q[j] <= '0;
      sel1_q <= '0;
      sel2_q <= '0;
      cnt_q  <= '0;
    end else if (bus.advance) begin
      sh_q   <= sh_d;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.stall           = stall;
  assign bus.of_bypass_src1  = bus.of_valid & hit(sh_q[DEPTH-1], use1, src1);
  assign bus.of_bypass_src2  = bus.of_valid & hit(sh_q[DEPTH-1], use2, src2);
  assign bus.ex_fwd_sel_src1 = sel1_q;
  assign bus.ex_fwd_sel_src2 = sel2_q;
  assign bus.ex_valid        = sh_q[0].v;
  assign bus.stall_count     = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit_p.sv
// tb_fwd_hazard_unit_p: directed vectors with a cycle-stamped scoreboard checked mid-cycle
module tb_fwd_hazard_unit_p;
  localparam int ST = 0, B1 = 1, B2 = 2, S1 = 3, S2 = 4, EV = 5, CN = 6;

  typedef struct {
    int    cyc;
    string n;
    bit    d;
    int    f;
    int    v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_unit_p_if #(.SEL_W(2), .CNT_W(16)) ifa ();
  fwd_hazard_unit_p_if #(.SEL_W(3), .CNT_W(4))  ifb ();

  fwd_hazard_unit_p #(.DEPTH(3), .SEL_W(2), .RA_REG(15), .HAS_ZERO_REG(0), .CNT_W(16))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  fwd_hazard_unit_p #(.DEPTH(5), .SEL_W(3), .RA_REG(15), .HAS_ZERO_REG(1), .CNT_W(4))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  function automatic logic [31:0] enc(logic [4:0] op, logic i, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
    return {op, i, rd, rs1, rs2, 14'b0};
  endfunction

  function automatic logic [31:0] act(bit d, int f);
    case (f)
      ST:      return d ? 32'(ifb.stall)           : 32'(ifa.stall);
      B1:      return d ? 32'(ifb.of_bypass_src1)  : 32'(ifa.of_bypass_src1);
      B2:      return d ? 32'(ifb.of_bypass_src2)  : 32'(ifa.of_bypass_src2);
      S1:      return d ? 32'(ifb.ex_fwd_sel_src1) : 32'(ifa.ex_fwd_sel_src1);
      S2:      return d ? 32'(ifb.ex_fwd_sel_src2) : 32'(ifa.ex_fwd_sel_src2);
      EV:      return d ? 32'(ifb.ex_valid)        : 32'(ifa.ex_valid);
      default: return d ? 32'(ifb.stall_count)     : 32'(ifa.stall_count);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      a = act(e.d, e.f);
      total++;
      if (a !== 32'(e.v)) begin
        bad++;
        $display("FAIL %s (dut %0d cyc %0d): got %0d want %0d", e.n, e.d, e.cyc, a, e.v);
      end
    end
  end

  task automatic step(bit d, logic [31:0] ir, bit v, bit adv = 1'b1, bit fl = 1'b0, bit rs = 1'b0);
    @(posedge clk);
    #1;
    if (d) begin
      ifb.of_ir = ir; ifb.of_valid = v; ifb.advance = adv; ifb.flush = fl; rst_b = rs;
    end else begin
      ifa.of_ir = ir; ifa.of_valid = v; ifa.advance = adv; ifa.flush = fl; rst_a = rs;
    end
    cyc++;
  endtask

  task automatic ex(string n, bit d, int f, int v);
    exp_t e;
    e.cyc = cyc; e.n = n; e.d = d; e.f = f; e.v = v;
    sb.push_back(e);
  endtask

  task automatic idle(bit d, int k);
    repeat (k) step(d, 32'h0, 1'b0);
  endtask

  task automatic all_zero(string n, bit d);
    for (int f = 0; f <= CN; f++) ex(n, d, f, 0);
  endtask

  logic [31:0] add1, sub1, ld1, mov16, call_i, ret_i, nop_i, add0, sub0, ld0;

  initial begin
    add1 = 32'h0048C000; sub1 = 32'h09054000; ld1 = 32'h74480000;
    mov16 = enc(5'b01001, 1'b0, 4'd1, 4'd0, 4'd6);
    call_i = enc(5'b10011, 1'b0, 4'd0, 4'd0, 4'd0);
    ret_i = enc(5'b10100, 1'b0, 4'd0, 4'd0, 4'd0);
    nop_i = enc(5'b01101, 1'b0, 4'd0, 4'd0, 4'd0);
    add0 = enc(5'b00000, 1'b0, 4'd0, 4'd2, 4'd3);
    sub0 = enc(5'b00001, 1'b0, 4'd4, 4'd0, 4'd5);
    ld0 = enc(5'b01110, 1'b1, 4'd0, 4'd2, 4'd0);
    ifa.of_ir = '0; ifa.of_valid = 1'b0; ifa.advance = 1'b1; ifa.flush = 1'b0;
    ifb.of_ir = '0; ifb.of_valid = 1'b0; ifb.advance = 1'b1; ifb.flush = 1'b0;

    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0); all_zero("a_reset", 0);
    // back-to-back ALU dependency
    step(0, add1, 1); ex("b2b_stall0", 0, ST, 0);
    step(0, sub1, 1); ex("b2b_stall1", 0, ST, 0); ex("b2b_add_ex", 0, EV, 1); ex("b2b_add_sel", 0, S1, 0);
    step(0, 0, 0); ex("b2b_sel1", 0, S1, 1); ex("b2b_sel2", 0, S2, 0); ex("b2b_ex", 0, EV, 1);
    // add r1 now in RW
    step(0, sub1, 1); ex("rw_byp1", 0, B1, 1); ex("rw_byp2", 0, B2, 0); ex("rw_ex_bubble", 0, EV, 0);
    step(0, 0, 0); ex("rw_sel1", 0, S1, 0); ex("rw_ex", 0, EV, 1);
    idle(0, 3);
    // load-use
    step(0, ld1, 1); ex("lu_nostall", 0, ST, 0);
    step(0, sub1, 1); ex("lu_stall", 0, ST, 1); ex("lu_cnt0", 0, CN, 0); ex("lu_ld_ex", 0, EV, 1);
    step(0, sub1, 1); ex("lu_stall_off", 0, ST, 0); ex("lu_cnt1", 0, CN, 1); ex("lu_bubble", 0, EV, 0);
    step(0, 0, 0); ex("lu_sel1", 0, S1, 2); ex("lu_sel2", 0, S2, 0); ex("lu_ex", 0, EV, 1);
    idle(0, 3);
    // WAW: younger mov wins
    step(0, add1, 1); step(0, mov16, 1);
    step(0, sub1, 1); ex("waw_nostall", 0, ST, 0);
    step(0, 0, 0); ex("waw_sel1", 0, S1, 1); ex("waw_sel2", 0, S2, 0);
    idle(0, 3);
    step(0, call_i, 1); step(0, ret_i, 1);
    step(0, 0, 0); ex("ret_sel1", 0, S1, 1); ex("ret_sel2", 0, S2, 0);
    idle(0, 3);
    // freeze with load in EX, then flush
    step(0, ld1, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, sub1, 1, 0); ex("frz_stall", 0, ST, 1); ex("frz_cnt", 0, CN, 1); ex("frz_ex", 0, EV, 1);
    end
    step(0, sub1, 1, 1, 1); ex("fl_stall", 0, ST, 0); ex("fl_cnt", 0, CN, 1); ex("fl_ex", 0, EV, 1);
    step(0, 0, 0); ex("fl_bubble", 0, EV, 0); ex("fl_sel1", 0, S1, 0); ex("fl_cnt2", 0, CN, 1);
    idle(0, 3);
    // reset mid-stream
    step(0, add1, 1); step(0, sub1, 1);
    step(0, ld1, 1, 1, 0, 1); ex("mid_sel1", 0, S1, 1);
    step(0, 0, 0); all_zero("mid_reset", 0);

    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0); ex("b_rst_cnt", 1, CN, 0); ex("b_rst_ex", 1, EV, 0);
    // producer four ahead
    step(1, add1, 1); repeat (3) step(1, nop_i, 1);
    step(1, sub1, 1); ex("d5_4_byp", 1, B1, 0);
    step(1, 0, 0); ex("d5_4_sel1", 1, S1, 4); ex("d5_4_sel2", 1, S2, 0);
    idle(1, 5);
    // producer five ahead
    step(1, add1, 1); repeat (4) step(1, nop_i, 1);
    step(1, sub1, 1); ex("d5_5_byp1", 1, B1, 1); ex("d5_5_byp2", 1, B2, 0);
    step(1, 0, 0); ex("d5_5_sel1", 1, S1, 0); ex("d5_5_ex", 1, EV, 1);
    idle(1, 5);
    // r0 never matches
    step(1, add0, 1); step(1, sub0, 1);
    step(1, nop_i, 1); ex("z_sel1", 1, S1, 0); ex("z_ex", 1, EV, 1);
    step(1, nop_i, 1); step(1, nop_i, 1);
    step(1, sub0, 1); ex("z_byp1", 1, B1, 0);
    idle(1, 5);
    step(1, ld0, 1); step(1, sub0, 1); ex("z_ld_nostall", 1, ST, 0);
    idle(1, 5);
    // counter saturation
    for (int k = 0; k < 20; k++) begin
      step(1, ld1, 1);
      step(1, sub1, 1); ex("sat_stall", 1, ST, 1); ex("sat_cnt", 1, CN, k < 15 ? k : 15);
      step(1, sub1, 1);
    end
    step(1, 0, 0); ex("sat_final", 1, CN, 15);

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      bad += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
